// File: rtl/d_flip_flop.sv
// Positive-edge D register with synchronous active-high reset; Q comes straight from the flop.
// Optional inverted output Qn is enabled by defining D_FLIP_FLOP_QN_EN.
module d_flip_flop #(
   parameter int                WIDTH       = 1,
   parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
`ifdef D_FLIP_FLOP_QN_EN
   ,
   output logic [WIDTH-1:0] Qn
`endif
);

   if (WIDTH < 1) begin : g_width_err
      $error("d_flip_flop: WIDTH must be at least 1");
   end

   logic [WIDTH-1:0] r_q;

   // Reset wins over D; both are only looked at on the rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= RESET_VALUE;
      end else begin
         r_q <= D;
      end
   end

   assign Q = r_q;

`ifdef D_FLIP_FLOP_QN_EN
   assign Qn = ~r_q;
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed self-checking bench for d_flip_flop: a 1-bit default instance and an
// 8-bit instance with RESET_VALUE 8'hA5 (Qn also checked when D_FLIP_FLOP_QN_EN is defined).
module tb_d_flip_flop;

   logic       clk;
   logic       reset;
   logic [0:0] d1;
   logic [0:0] q1;
   logic [7:0] d8;
   logic [7:0] q8;
`ifdef D_FLIP_FLOP_QN_EN
   logic [0:0] qn1;
   logic [7:0] qn8;
`endif

   int n_checks;
   int n_errors;

   d_flip_flop u_dut1 (
      .clk   (clk),
      .reset (reset),
      .D     (d1),
      .Q     (q1)
`ifdef D_FLIP_FLOP_QN_EN
      ,
      .Qn    (qn1)
`endif
   );

   d_flip_flop #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .D     (d8),
      .Q     (q8)
`ifdef D_FLIP_FLOP_QN_EN
      ,
      .Qn    (qn8)
`endif
   );

   // First rising edge at 5 ns, period 10 ns.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       reset;
      logic       d1;
      logic [7:0] d8;
      logic       exp_q1;
      logic [7:0] exp_q8;
   } vec_t;

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name, input logic e1, input logic [7:0] e8);
      check1({name, "_q1"}, q1, e1);
      check8({name, "_q8"}, q8, e8);
`ifdef D_FLIP_FLOP_QN_EN
      check1({name, "_qn1"}, qn1, ~e1);
      check8({name, "_qn8"}, qn8, ~e8);
`endif
   endtask

   vec_t vecs[9];

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      d1       = 1'b0;
      d8       = 8'h00;

      //          reset  d1    d8      q1    q8
      vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hA5};  // first reset edge
      vecs[1] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5};  // reset held, D ignored
      vecs[2] = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C};  // release: loads D same edge
      vecs[3] = '{1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[5] = '{1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF};
      vecs[6] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5};  // reset priority over D
      vecs[7] = '{1'b0, 1'b0, 8'h5A, 1'b0, 8'h5A};
      vecs[8] = '{1'b0, 1'b1, 8'h81, 1'b1, 8'h81};

      for (int i = 0; i < 9; i++) begin
         if (i != 0) @(negedge clk);
         reset = vecs[i].reset;
         d1    = vecs[i].d1;
         d8    = vecs[i].d8;
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].exp_q1, vecs[i].exp_q8);
      end

      // Mid-cycle D toggles must not reach Q before the next edge.
      @(negedge clk);
      d1 = 1'b0;
      d8 = 8'h00;
      #2;
      d1 = 1'b1;
      d8 = 8'hFF;
      #1;
      check_all("hold_mid", 1'b1, 8'h81);
      #1;
      d1 = 1'b0;
      d8 = 8'h42;
      @(posedge clk);
      #1;
      check_all("hold_edge", 1'b0, 8'h42);

      // Short reset pulse that spans no rising edge leaves Q alone.
      @(negedge clk);
      d1 = 1'b1;
      d8 = 8'h99;
      @(posedge clk);
      #1;
      check_all("pulse_load", 1'b1, 8'h99);
      #1;
      reset = 1'b1;
      #1;
      check_all("pulse_mid", 1'b1, 8'h99);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_all("pulse_after", 1'b1, 8'h99);

      // Reset held over several edges with D moving, then released.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         reset = 1'b1;
         d1    = k[0];
         d8    = 8'h10 + 8'(k);
         @(posedge clk);
         #1;
         check_all($sformatf("rst_hold%0d", k), 1'b0, 8'hA5);
      end
      @(negedge clk);
      reset = 1'b0;
      d1    = 1'b1;
      d8    = 8'h3C;
      @(posedge clk);
      #1;
      check_all("rst_release", 1'b1, 8'h3C);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
